// File: rtl/cp_insert_pkg.sv
// Shared defaults, read-FSM state type and sample layout for the cyclic-prefix insertion stage.
package facc_cp_pkg;

    localparam int unsigned NFFT_DEF    = 4096;
    localparam int unsigned AW_DEF      = 12;
    localparam int unsigned CP_LEN_DEF  = 288;
    localparam int unsigned CP_LONG_DEF = 352;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CP   = 2'd1,
        ST_BODY = 2'd2
    } rd_state_e;

    // Packed as {imag, real} so a sample maps directly onto one 32-bit buffer word.
    typedef struct packed {
        logic [15:0] im;
        logic [15:0] re;
    } sample_t;

    function automatic int unsigned cp_for_symbol(input logic [3:0]  sym,
                                                  input int unsigned cp_len,
                                                  input int unsigned cp_long);
        return (sym == 4'd0) ? cp_long : cp_len;
    endfunction

endpackage

// File: rtl/cp_insert_if.sv
// Sample stream into and out of the cyclic-prefix inserter, plus its error pulses.
interface cp_insert_if;

    // Neither direction has backpressure: a sample transfers on every cycle its
    // valid is high; sop/eop/symbol are qualified by the same valid.
    logic        din_valid;
    logic        din_sop;
    logic        din_eop;
    logic [15:0] din_real;
    logic [15:0] din_imag;
    logic [3:0]  din_symbol;

    logic        dout_valid;
    logic        dout_sop;
    logic        dout_eop;
    logic [15:0] dout_real;
    logic [15:0] dout_imag;
    logic        overflow;
    logic        len_err;

    modport master (
        output din_valid, din_sop, din_eop, din_real, din_imag, din_symbol,
        input  dout_valid, dout_sop, dout_eop, dout_real, dout_imag, overflow, len_err
    );

    modport slave (
        input  din_valid, din_sop, din_eop, din_real, din_imag, din_symbol,
        output dout_valid, dout_sop, dout_eop, dout_real, dout_imag, overflow, len_err
    );

endinterface

// File: rtl/cp_buf_ram.sv
// Simple dual-port sample RAM: one write port, one read port with a registered output.
module cp_buf_ram #(
    parameter int unsigned AW = 13,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cp_insert.sv
// Captures each OFDM symbol into a ping-pong buffer and replays it prefixed by its
// last cp_len samples (long CP on symbol 0 of a slot, normal CP otherwise).
module cp_insert
    import facc_cp_pkg::*;
#(
    parameter int unsigned NFFT    = NFFT_DEF,
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned CP_LEN  = CP_LEN_DEF,
    parameter int unsigned CP_LONG = CP_LONG_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    cp_insert_if.slave bus,
    output rd_state_e  dbg_state_o
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NFFT - 1);
    localparam logic [AW:0]   NFFT_W    = (AW+1)'(NFFT);

    // First address of the CP region for a bank holding a symbol with this CP length.
    function automatic logic [AW-1:0] cp_start(input logic [AW:0] len);
        logic [AW:0] s;
        s = NFFT_W - len;
        return s[AW-1:0];
    endfunction

    // Write side
    logic                wr_bank_q, wr_bank_d;
    logic                wr_open_q, wr_open_d;
    logic                wr_drop_q, wr_drop_d;
    logic [AW-1:0]       wr_addr_q, wr_addr_d;
    logic [1:0]          full_q, full_d;
    logic [1:0][AW:0]    cplen_q, cplen_d;
    logic                ovf_q, ovf_d;
    logic                lerr_q, lerr_d;
    logic                set_full;
    logic                bank_busy;
    logic                ram_we;
    logic [AW-1:0]       ram_waddr;
    sample_t             wr_sample;

    // Read side
    rd_state_e           state_q, state_d;
    logic                rd_bank_q, rd_bank_d;
    logic [AW-1:0]       rd_addr_q, rd_addr_d;
    logic                rd_en, rd_sop, rd_eop, release_c;
    logic [AW-1:0]       rd_addr_c;
    logic                v1_q, sop1_q, eop1_q;
    logic [31:0]         ram_rdata;
    sample_t             rd_sample;

    // Output register
    logic                dout_valid_q, dout_sop_q, dout_eop_q;
    sample_t             dout_q;

    assign wr_sample.im = bus.din_imag;
    assign wr_sample.re = bus.din_real;
    assign rd_sample    = sample_t'(ram_rdata);

    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_open_d = wr_open_q;
        wr_drop_d = wr_drop_q;
        wr_addr_d = wr_addr_q;
        cplen_d   = cplen_q;
        set_full  = 1'b0;
        ovf_d     = 1'b0;
        lerr_d    = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = wr_addr_q;
        // A bank released by the reader this very cycle counts as free.
        bank_busy = full_q[wr_bank_q] & ~(release_c & (rd_bank_q == wr_bank_q));

        if (bus.din_valid) begin
            if (bus.din_sop) begin
                wr_drop_d = 1'b0;
                if (wr_open_q) lerr_d = 1'b1;
                if (bank_busy) begin
                    ovf_d     = 1'b1;
                    wr_open_d = 1'b0;
                    wr_drop_d = ~bus.din_eop;
                end else begin
                    wr_open_d = 1'b1;
                    wr_addr_d = '0;
                    ram_we    = 1'b1;
                    ram_waddr = '0;
                    cplen_d[wr_bank_q] = (AW+1)'(cp_for_symbol(bus.din_symbol, CP_LEN, CP_LONG));
                    if (bus.din_eop) begin
                        lerr_d    = 1'b1;
                        wr_open_d = 1'b0;
                    end
                end
            end else if (wr_open_q) begin
                wr_addr_d = wr_addr_q + 1'b1;
                ram_we    = 1'b1;
                ram_waddr = wr_addr_d;
                if (wr_addr_d == LAST_ADDR) begin
                    wr_open_d = 1'b0;
                    if (bus.din_eop) begin
                        set_full  = 1'b1;
                        wr_bank_d = ~wr_bank_q;
                    end else begin
                        lerr_d = 1'b1;
                    end
                end else if (bus.din_eop) begin
                    lerr_d    = 1'b1;
                    wr_open_d = 1'b0;
                end
            end else if (wr_drop_q && bus.din_eop) begin
                wr_drop_d = 1'b0;
            end
        end
    end

    always_comb begin
        full_d = full_q;
        if (release_c) full_d[rd_bank_q] = 1'b0;
        if (set_full)  full_d[wr_bank_q] = 1'b1;
    end

    // Reader: IDLE issues the first CP read in the same cycle it sees the bank
    // full, so the first output sample lands three cycles after the input eop.
    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        rd_addr_d = rd_addr_q;
        rd_en     = 1'b0;
        rd_addr_c = rd_addr_q;
        rd_sop    = 1'b0;
        rd_eop    = 1'b0;
        release_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    rd_en     = 1'b1;
                    rd_sop    = 1'b1;
                    rd_addr_c = cp_start(cplen_q[rd_bank_q]);
                    if (rd_addr_c == LAST_ADDR) begin
                        state_d   = ST_BODY;
                        rd_addr_d = '0;
                    end else begin
                        state_d   = ST_CP;
                        rd_addr_d = rd_addr_c + 1'b1;
                    end
                end
            end
            ST_CP: begin
                rd_en  = 1'b1;
                rd_sop = (rd_addr_q == cp_start(cplen_q[rd_bank_q]));
                if (rd_addr_q == LAST_ADDR) begin
                    state_d   = ST_BODY;
                    rd_addr_d = '0;
                end else begin
                    rd_addr_d = rd_addr_q + 1'b1;
                end
            end
            ST_BODY: begin
                rd_en = 1'b1;
                if (rd_addr_q == LAST_ADDR) begin
                    rd_eop    = 1'b1;
                    release_c = 1'b1;
                    rd_bank_d = ~rd_bank_q;
                    if (full_q[~rd_bank_q]) begin
                        state_d   = ST_CP;
                        rd_addr_d = cp_start(cplen_q[~rd_bank_q]);
                    end else begin
                        state_d   = ST_IDLE;
                        rd_addr_d = '0;
                    end
                end else begin
                    rd_addr_d = rd_addr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= 1'b0;
            wr_open_q <= 1'b0;
            wr_drop_q <= 1'b0;
            wr_addr_q <= '0;
            full_q    <= '0;
            cplen_q   <= '0;
            ovf_q     <= 1'b0;
            lerr_q    <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            wr_open_q <= wr_open_d;
            wr_drop_q <= wr_drop_d;
            wr_addr_q <= wr_addr_d;
            full_q    <= full_d;
            cplen_q   <= cplen_d;
            ovf_q     <= ovf_d;
            lerr_q    <= lerr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rd_bank_q    <= 1'b0;
            rd_addr_q    <= '0;
            v1_q         <= 1'b0;
            sop1_q       <= 1'b0;
            eop1_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_sop_q   <= 1'b0;
            dout_eop_q   <= 1'b0;
            dout_q       <= '0;
        end else begin
            state_q      <= state_d;
            rd_bank_q    <= rd_bank_d;
            rd_addr_q    <= rd_addr_d;
            v1_q         <= rd_en;
            sop1_q       <= rd_sop;
            eop1_q       <= rd_eop;
            dout_valid_q <= v1_q;
            dout_sop_q   <= sop1_q;
            dout_eop_q   <= eop1_q;
            dout_q       <= v1_q ? rd_sample : '0;
        end
    end

    cp_buf_ram #(
        .AW (AW + 1),
        .DW (32)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i ({wr_bank_q, ram_waddr}),
        .wdata_i (wr_sample),
        .re_i    (rd_en),
        .raddr_i ({rd_bank_q, rd_addr_c}),
        .rdata_o (ram_rdata)
    );

    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_sop   = dout_sop_q;
    assign bus.dout_eop   = dout_eop_q;
    assign bus.dout_real  = dout_q.re;
    assign bus.dout_imag  = dout_q.im;
    assign bus.overflow   = ovf_q;
    assign bus.len_err    = lerr_q;
    assign dbg_state_o    = state_q;

endmodule

// File: doc/cp_insert.md
# cp_insert

Cyclic-prefix insertion stage directly downstream of the TX phase-compensation stage in the harden_tx_top chain. It captures each compensated time-domain OFDM symbol of NFFT samples into a ping-pong buffer. It then streams out the last CP samples of that symbol followed by the whole symbol. The long CP is used on symbol 0 of each slot and the normal CP on all other symbols.

## Interface
- NFFT, 4096: samples per symbol (power of two).
- AW, 12: log2(NFFT).
- CP_LEN, 288: normal CP length in samples.
- CP_LONG, 352: long CP length, used when symbol index is 0; must be ≤ NFFT.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- din_valid  in  1  input sample strobe; no backpressure.
- din_sop  in  1  first sample of symbol.
- din_eop  in  1  last sample of symbol.
- din_real  in  16  I sample.
- din_imag  in  16  Q sample.
- din_symbol  in  4  symbol-in-slot index (0..13), sampled with din_sop.
- dout_valid  out  1  output sample strobe.
- dout_sop  out  1  first CP sample.
- dout_eop  out  1  last body sample.
- dout_real  out  16  I out.
- dout_imag  out  16  Q out.
- overflow  out  1  one-cycle pulse: symbol dropped because both banks are full.
- len_err  out  1  one-cycle pulse: symbol discarded because its length was wrong.

## Operation
- Buffer: 2 banks × NFFT words, 32 bits each ({imag, real}). Each bank has a full flag and a latched cp_len.
- Write side:
  - din_valid & din_sop: target bank wr_bank, write address 0. cp_len = (din_symbol==0) ? CP_LONG : CP_LEN.
  - Each further valid sample writes at address+1.
  - din_valid & din_eop at address NFFT-1: set full[wr_bank], toggle wr_bank.
  - Samples with din_valid and no open symbol are ignored.
- Length error → len_err pulse, bank not marked full, symbol discarded. Causes:
  - eop at an address other than NFFT-1.
  - sop while a symbol is still open; the new sop restarts the write at address 0 in the same bank.
  - address reaching NFFT-1 without eop.
- sop with full[wr_bank]=1 → overflow pulse, whole symbol ignored up to its eop.
- Read FSM (states IDLE, CP, BODY):
  - IDLE: when full[rd_bank], go to CP with rd_addr = NFFT - cp_len.
  - CP: read one sample per cycle; at rd_addr = NFFT-1 go to BODY with rd_addr = 0.
  - BODY: read one sample per cycle. At NFFT-1, clear full[rd_bank] and toggle rd_bank. If the other bank is full, go directly to CP (back-to-back output); otherwise go to IDLE.
- Output runs at 1 sample/clock for NFFT+cp_len cycles, with no gaps inside a symbol.
- Upstream must average ≤ NFFT/(NFFT+CP) input duty; excess appears as overflow.
- Samples pass bit-exact; no arithmetic, no width change.

## Timing
- Reset value of every output is 0. Reset mid-symbol clears all flags and banks to empty, FSM to IDLE, wr_bank = rd_bank = 0; a partially output symbol is truncated with no eop.
- RAM read latency 1 cycle, plus an output register: dout lags the read address by 2 cycles.
- Latency: din_eop at cycle t → full set at t+1 → first read at t+1 → dout_sop at t+3.
- dout_sop and dout_eop are each high for exactly one cycle, coincident with dout_valid.
- Simultaneous events:
  - BODY releasing bank B in the same cycle that sop targets bank B: the release wins, so the write is accepted with no overflow.
  - eop setting full on the bank the FSM is polling in IDLE: that bank is seen full the next cycle.
- Write and read never address the same bank concurrently, because of the full-flag protocol.

## Structure
- Package facc_cp_pkg holds the NFFT, CP_LEN and CP_LONG defaults, the state enum {IDLE, CP, BODY}, and the sample typedef (struct of 16-bit real and imag).
- Sub-module cp_buf_ram: simple dual-port RAM, depth 2·NFFT, 32-bit data, 1-cycle registered read, address = {bank, AW-bit addr}.

## Test plan
All scenarios use NFFT=64, CP_LEN=8, CP_LONG=12.
- Single symbol, din_symbol=3, samples 0..63 → dout = 56..63 then 0..63 (72 cycles), dout_sop at eop+3, dout_eop on sample 63.
- din_symbol=0 → 12-sample CP, samples 52..63 then 0..63 (76 cycles).
- Two symbols back-to-back at full input rate, then a third arriving before the first output finishes → first two output gap-free, third gives overflow pulse and is absent from dout.
- eop after 40 samples → len_err pulse, no output. Next valid symbol then outputs correctly from the same bank.
- rst_n asserted in the middle of BODY → all outputs 0 the next cycle. The next symbol after reset outputs from bank 0 with correct CP.
- Release/sop collision: second-bank sop in the exact cycle bank 0 finishes BODY while bank 1 holds data → no overflow, all three symbols output in order.
